// File: rtl/cipher_pkg.sv
// Shared definitions for the nibble cipher: widths, S-box table, GF(2^4)
// helpers and the iterative encoder's FSM states.
// Build option: ENCODER_FINAL_KEY_EN adds a key XOR after the last round.
package cipher_pkg;

   localparam int NIB_W = 4;
   localparam int BLK_W = 16;

   // S-box, entry i lives in bits [4*i +: 4] (entry 0 at the LSB).
   localparam logic [63:0] SBOX_TABLE = 64'h7095_C6A3_8BF2_1D4E;

`ifdef ENCODER_FINAL_KEY_EN
   localparam bit FINAL_KEY_EN = 1'b1;
`else
   localparam bit FINAL_KEY_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } enc_state_e;

   function automatic logic [NIB_W-1:0] sbox(input logic [NIB_W-1:0] n);
      return SBOX_TABLE[{n, 2'b00} +: NIB_W];
   endfunction

   // Multiply by x, reduced mod x^4+x+1 (overflow bit folds back as x+1).
   function automatic logic [NIB_W-1:0] gf_mul2(input logic [NIB_W-1:0] a);
      return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
   endfunction

   function automatic logic [NIB_W-1:0] gf_mul3(input logic [NIB_W-1:0] a);
      return gf_mul2(a) ^ a;
   endfunction

endpackage

// File: rtl/enc_round.sv
// One combinational cipher round: key XOR, S-box, row shift, column mix,
// plus the optional final whitening XOR on the last round.
module enc_round
   import cipher_pkg::*;
(
   input  logic [BLK_W-1:0] state_i,
   input  logic [BLK_W-1:0] key_i,
   input  logic             final_i,
   output logic [BLK_W-1:0] next_o
);

   logic [BLK_W-1:0] x;
   logic [NIB_W-1:0] s0, s1, s2, s3;
   logic [NIB_W-1:0] r0, r1, r2, r3;
   logic [BLK_W-1:0] mixed;

   assign x  = state_i ^ key_i;
   assign s0 = sbox(x[15:12]);
   assign s1 = sbox(x[11:8]);
   assign s2 = sbox(x[7:4]);
   assign s3 = sbox(x[3:0]);

   // Row shift swaps n1 and n3; columns are then (r0,r1) and (r2,r3).
   assign r0 = s0;
   assign r1 = s3;
   assign r2 = s2;
   assign r3 = s1;

   assign mixed = {gf_mul3(r0) ^ gf_mul2(r1), gf_mul2(r0) ^ gf_mul3(r1),
                   gf_mul3(r2) ^ gf_mul2(r3), gf_mul2(r2) ^ gf_mul3(r3)};

   assign next_o = (FINAL_KEY_EN && final_i) ? (mixed ^ key_i) : mixed;

endmodule

// File: rtl/encoder_iter.sv
// Iterative nibble-cipher encryptor: accepts a block, runs NUM_ROUNDS rounds
// (one per clock) with the captured key, then holds the ciphertext until the
// downstream handshake. Build option: ENCODER_FINAL_KEY_EN (final key XOR).
module encoder_iter
   import cipher_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_message,
   input  logic [BLK_W-1:0] in_key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_message
);

   localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

   enc_state_e       fsm_q, fsm_d;
   logic [BLK_W-1:0] msg_q, msg_d;
   logic [BLK_W-1:0] key_q, key_d;
   logic [BLK_W-1:0] out_q, out_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             is_last;
   logic [BLK_W-1:0] round_out;

   assign is_last = (cnt_q == LAST_CNT);

   enc_round u_round (
      .state_i (msg_q),
      .key_i   (key_q),
      .final_i (is_last),
      .next_o  (round_out)
   );

   // Handshake outputs depend only on registered state (and rst for in_ready).
   assign in_ready    = (fsm_q == ST_IDLE) && !rst;
   assign out_valid   = (fsm_q == ST_DONE);
   assign out_message = out_q;

   // Next-state logic: load in IDLE, one round per BUSY cycle, hold in DONE.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
      fsm_d = fsm_q;
      msg_d = msg_q;
      key_d = key_q;
      cnt_d = cnt_q;
      out_d = out_q;
      unique case (fsm_q)
         ST_IDLE: begin
            if (in_valid) begin
               msg_d = in_message;
               key_d = in_key;
               cnt_d = 4'd0;
               fsm_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            msg_d = round_out;
            cnt_d = cnt_q + 4'd1;
            if (is_last) begin
               out_d = round_out;
               fsm_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) fsm_d = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   // State registers; synchronous reset overrides any pending transition.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         fsm_q <= ST_IDLE;
         msg_q <= '0;
         key_q <= '0;
         out_q <= '0;
         cnt_q <= 4'd0;
      end else begin
         fsm_q <= fsm_d;
         msg_q <= msg_d;
         key_q <= key_d;
         out_q <= out_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: doc/encoder_iter.md
# encoder_iter

Iterative 16-bit nibble-cipher encryptor; the forward-direction counterpart of the team's single-round `decoder`. Each round is key XOR, nibble S-box, row shift and column mix, applied one round per clock. `NUM_ROUNDS` rounds with the same key run between a valid/ready input handshake and a valid/ready output handshake. With `NUM_ROUNDS`=1 and `ENCODER_FINAL_KEY_EN` undefined, `decoder(out_message, in_key)` returns the original `in_message`.

## Interface
- `NUM_ROUNDS`, default 1, number of rounds per block; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_message`/`in_key` are offered.
- `in_ready` output 1: block accepts input; high only in IDLE.
- `in_message` input 16: plaintext; nibble n0=[15:12], n1=[11:8], n2=[7:4], n3=[3:0].
- `in_key` input 16: key; captured at acceptance.
- `out_valid` output 1: `out_message` holds a finished ciphertext.
- `out_ready` input 1: downstream consumes the ciphertext.
- `out_message` output 16: ciphertext, registered.

## Operation
- State matrix, column-major: col0=(n0,n1), col1=(n2,n3).
- Round function, in order:
  - t = s ^ key.
  - S-box per nibble: 0→E 1→4 2→D 3→1 4→2 5→F 6→B 7→8 8→3 9→A A→6 B→C C→5 D→9 E→0 F→7.
  - Shift row: swap n1 and n3.
  - Mix each column (a,b) → (3a^2b, 2a^3b), arithmetic in GF(2^4) mod x^4+x+1.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, load state register ← `in_message` and key register ← `in_key`, clear round counter, go to BUSY.
  - BUSY: each cycle, state ← round(state, key) and counter+1. On the edge applying round `NUM_ROUNDS`, go to DONE.
  - DONE: `out_valid`=1 and `out_message`=state, both held stable. On `out_ready`, go to IDLE.
- `in_key`/`in_message` changes after acceptance have no effect.
- `out_ready` asserted outside DONE is ignored.
- `in_valid` outside IDLE is ignored; nothing is queued.
- Round counter is 4 bits; it never wraps because `NUM_ROUNDS` ≤ 15.

## Timing
- Reset: state register, key register, counter and `out_message` = 0x0000; FSM=IDLE; `out_valid`=0.
- `in_ready` = (FSM==IDLE) && !`rst`.
- `rst` has priority over every event. Reset asserted in BUSY or DONE aborts the block; the result is discarded.
- Latency: `out_valid` rises `NUM_ROUNDS`+1 rising edges after the accepting edge (one load edge plus one edge per round).
- Output handshake completes on the edge where `out_valid`&&`out_ready`. `in_ready` is high in the next cycle.
- Throughput: one block per `NUM_ROUNDS`+2 cycles when `out_ready` is tied high.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- `ENCODER_FINAL_KEY_EN` defined: the round applied in the last BUSY cycle additionally XORs the key after mixing (final whitening). `out_message` = MC(SR(SB(s^key)))^key.
- `ENCODER_FINAL_KEY_EN` undefined: no final XOR.
- Latency and handshake are identical in both builds.

## Structure
- Shared package `cipher_pkg` holds:
  - nibble and block width constants (4, 16);
  - the S-box constant table;
  - the GF(2^4) multiply-by-2 and multiply-by-3 functions;
  - the FSM state enum (IDLE/BUSY/DONE).
- One combinational sub-module `enc_round` (state, key, final flag → next state) implements a single round.
- `encoder_iter` contains the FSM, the counter, the registers and one `enc_round` instance.

## Test plan
- `NUM_ROUNDS`=1, key 0x0000, in 0x1234 → `out_message`=0x8EA6, `out_valid` high 2 edges after acceptance.
- `NUM_ROUNDS`=1, key 0xFFFF, in 0xFFFF → 0xEEEE; with `ENCODER_FINAL_KEY_EN` → 0x1111.
- `NUM_ROUNDS`=2, key 0x0000, in 0x0000 → 0x0000 after 3 edges; `in_ready` low throughout BUSY and DONE.
- `out_ready` held low for 5 cycles in DONE → `out_message` stable and `out_valid` high; a second `in_valid` is ignored. Raise `out_ready` → next cycle `in_ready`=1.
- `rst` pulsed in the first BUSY cycle → next cycle `out_valid`=0, `out_message`=0x0000, `in_ready`=1; a new block then encrypts correctly.
- Random key/message with `NUM_ROUNDS`=1, result fed to reference `decoder` → recovers `in_message` for 1000 vectors.
